// File: rtl/mole_game_fsm.sv
// mole_game_fsm: whack-a-mole game controller.
// Sequences start delay, mole requests on note ticks, whack/miss decisions,
// lives/score bookkeeping and game over. Drives the display mux state code
// and mole location, and issues one-cycle whack/miss sound pulses.
// Optional feature macro: MOLE_EARLY_WHACK_EN -- when defined, a matching
// stomp while the mole is still ascending counts as a whack.
module mole_game_fsm #(
    parameter int START_DELAY  = 130_000_000,
    parameter int MOLE_TIMEOUT = 97_500_000,
    parameter int SOUND_CYCLES = 32_500_000,
    parameter int LIVES_INIT   = 3,
    parameter int SCORE_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               note_tick,
    input  logic               stomp_valid,
    input  logic [2:0]         stomp_location,
    input  logic               popup_done,
    output logic [3:0]         state,
    output logic [2:0]         mole_location,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               whack_pulse,
    output logic               miss_pulse
);

    // State codes are fixed by the display mux that consumes them.
    localparam logic [3:0] IDLE                  = 4'd0;
    localparam logic [3:0] GAME_START_DELAY      = 4'd1;
    localparam logic [3:0] GAME_ONGOING          = 4'd2;
    localparam logic [3:0] REQUEST_MOLE          = 4'd3;
    localparam logic [3:0] MOLE_COUNTDOWN        = 4'd4;
    localparam logic [3:0] MOLE_MISSED           = 4'd5;
    localparam logic [3:0] MOLE_WHACKED          = 4'd6;
    localparam logic [3:0] GAME_OVER             = 4'd8;
    localparam logic [3:0] MOLE_MISSED_SOUND     = 4'd9;
    localparam logic [3:0] MOLE_WHACKED_SOUND    = 4'd10;
    localparam logic [3:0] MOLE_ASCENDING        = 4'd13;
    localparam logic [3:0] HAPPY_MOLE_DESCENDING = 4'd14;
    localparam logic [3:0] DEAD_MOLE_DESCENDING  = 4'd15;

    // Terminal timer values: a state lasting N cycles leaves when timer == N-1.
    localparam logic [27:0] START_LAST   = 28'(START_DELAY - 1);
    localparam logic [27:0] TIMEOUT_LAST = 28'(MOLE_TIMEOUT - 1);
    localparam logic [27:0] SOUND_LAST   = 28'(SOUND_CYCLES - 1);
    localparam logic [27:0] TIMER_MAX    = '1;

    localparam logic [2:0]         LIVES_RST = 3'(LIVES_INIT);
    localparam logic [7:0]         LFSR_SEED = 8'hB8;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [27:0] timer;
    logic [7:0]  lfsr;
    logic [3:0]  next_state;
    logic        stomp_hit;
    logic        lfsr_fb;

    // Score increment that sticks at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] score_sat_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
    endfunction

    // Lives decrement floored at zero.
    function automatic logic [2:0] lives_floor_dec(input logic [2:0] l);
        return (l == 3'd0) ? 3'd0 : l - 3'd1;
    endfunction

    // Never pop the same hole twice in a row: bump by one (mod 8) on a repeat.
    function automatic logic [2:0] pick_location(input logic [2:0] cand,
                                                 input logic [2:0] prev);
        return (cand == prev) ? cand + 3'd1 : cand;
    endfunction

    assign stomp_hit = stomp_valid && (stomp_location == mole_location);

    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting toward the MSB.
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // Next-state decode; unused codes (upsets) fall back to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) next_state = GAME_START_DELAY;
            end
            GAME_START_DELAY: begin
                if (timer == START_LAST) next_state = GAME_ONGOING;
            end
            GAME_ONGOING: begin
                if (lives == 3'd0)  next_state = GAME_OVER;
                else if (note_tick) next_state = REQUEST_MOLE;
            end
            REQUEST_MOLE: begin
                next_state = MOLE_ASCENDING;
            end
            MOLE_ASCENDING: begin
`ifdef MOLE_EARLY_WHACK_EN
                if (stomp_hit)       next_state = MOLE_WHACKED;
                else if (popup_done) next_state = MOLE_COUNTDOWN;
`else
                if (popup_done) next_state = MOLE_COUNTDOWN;
`endif
            end
            MOLE_COUNTDOWN: begin
                // A whack landing on the timeout cycle still counts as a whack.
                if (stomp_hit)                  next_state = MOLE_WHACKED;
                else if (timer == TIMEOUT_LAST) next_state = MOLE_MISSED;
            end
            MOLE_WHACKED: begin
                next_state = MOLE_WHACKED_SOUND;
            end
            MOLE_MISSED: begin
                next_state = MOLE_MISSED_SOUND;
            end
            MOLE_WHACKED_SOUND: begin
                if (timer == SOUND_LAST) next_state = DEAD_MOLE_DESCENDING;
            end
            MOLE_MISSED_SOUND: begin
                if (timer == SOUND_LAST) next_state = HAPPY_MOLE_DESCENDING;
            end
            HAPPY_MOLE_DESCENDING, DEAD_MOLE_DESCENDING: begin
                if (popup_done) next_state = GAME_ONGOING;
            end
            GAME_OVER: begin
                if (start) next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register and shared timer: cleared on any state change, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) timer <= '0;
            else if (timer != TIMER_MAX) timer <= timer + 28'd1;
        end
    end

    // Game bookkeeping, free-running LFSR and sound pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr          <= LFSR_SEED;
            mole_location <= 3'd0;
            lives         <= LIVES_RST;
            score         <= '0;
            whack_pulse   <= 1'b0;
            miss_pulse    <= 1'b0;
        end else begin
            lfsr        <= {lfsr[6:0], lfsr_fb};
            // Pulses coincide with the one-cycle WHACKED/MISSED states.
            whack_pulse <= (next_state == MOLE_WHACKED);
            miss_pulse  <= (next_state == MOLE_MISSED);
            case (state)
                IDLE: begin
                    if (start) begin
                        lives <= LIVES_RST;
                        score <= '0;
                    end
                end
                REQUEST_MOLE: begin
                    mole_location <= pick_location(lfsr[2:0], mole_location);
                end
                MOLE_WHACKED: begin
                    score <= score_sat_inc(score);
                end
                MOLE_MISSED: begin
                    lives <= lives_floor_dec(lives);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mole_game_fsm.md
# mole_game_fsm

Game controller for the whack-a-mole display pipeline. Runs the game flow: start, mole requests on music note ticks, whack/miss decisions, lives and score, game over. Drives the 4-bit `state` code and 3-bit `mole_location` consumed by the mole display mux, and takes back its `popup_done` handshake. Also issues one-cycle whack/miss pulses to the sound module.

## Interface

Parameters:
- `START_DELAY`, default 130_000_000: cycles spent in GAME_START_DELAY (2 s at 65 MHz).
- `MOLE_TIMEOUT`, default 97_500_000: cycles a fully raised mole waits before it counts as missed.
- `SOUND_CYCLES`, default 32_500_000: cycles spent in each *_SOUND state.
- `LIVES_INIT`, default 3: lives at game start, 1..7.
- `SCORE_W`, default 8: score width.

Ports:
- `clk` in 1: pixel/system clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: debounced single-cycle start pulse.
- `note_tick` in 1: single-cycle pulse from the music sequencer that requests a mole.
- `stomp_valid` in 1: single-cycle pulse, a pad was stomped.
- `stomp_location` in 3: pad index, valid with `stomp_valid`.
- `popup_done` in 1: display reports that ascent or descent finished; synchronous to `clk`.
- `state` out 4: game state code.
- `mole_location` out 3: current hole, 0..7.
- `lives` out 3: remaining lives.
- `score` out SCORE_W: whacked-mole count.
- `whack_pulse`, `miss_pulse` out 1 each: sound triggers.

## Operation

State codes are fixed:
- IDLE=0, GAME_START_DELAY=1, GAME_ONGOING=2, REQUEST_MOLE=3, MOLE_COUNTDOWN=4, MOLE_MISSED=5, MOLE_WHACKED=6, GAME_OVER=8, MOLE_MISSED_SOUND=9, MOLE_WHACKED_SOUND=10, MOLE_ASCENDING=13, HAPPY_MOLE_DESCENDING=14, DEAD_MOLE_DESCENDING=15.
- Codes 7, 11 and 12 are never entered. If one appears (upset), the next state is IDLE.

Transitions:
- IDLE: `start` → GAME_START_DELAY. Load `lives`=LIVES_INIT, clear `score` and the timer.
- GAME_START_DELAY: when timer == START_DELAY-1 → GAME_ONGOING.
- GAME_ONGOING: `lives`==0 → GAME_OVER (this check takes priority). Otherwise `note_tick` → REQUEST_MOLE.
- REQUEST_MOLE: lasts exactly 1 cycle.
  - `mole_location` ← `lfsr[2:0]`; if that equals the previous location, use (`lfsr[2:0]`+1) mod 8 instead.
  - Next state is MOLE_ASCENDING.
- MOLE_ASCENDING: `popup_done` → MOLE_COUNTDOWN with the timer cleared. Stomps are handled per Configuration.
- MOLE_COUNTDOWN:
  - `stomp_valid` && `stomp_location`==`mole_location` → MOLE_WHACKED.
  - Otherwise, when timer == MOLE_TIMEOUT-1 → MOLE_MISSED.
  - If both happen in the same cycle, the whack wins.
  - Stomps on a non-matching pad are ignored.
- MOLE_WHACKED (1 cycle): `score`+1, saturating at all-ones. `whack_pulse`=1. Next state is MOLE_WHACKED_SOUND.
- MOLE_MISSED (1 cycle): `lives`-1, floored at 0. `miss_pulse`=1. Next state is MOLE_MISSED_SOUND.
- *_SOUND states: wait SOUND_CYCLES, then go to DEAD_MOLE_DESCENDING (from whacked) or HAPPY_MOLE_DESCENDING (from missed).
- *_DESCENDING states: `popup_done` → GAME_ONGOING.
- GAME_OVER: `start` → IDLE. `score` and `lives` hold until then.

Other rules:
- `note_tick` pulses that arrive outside GAME_ONGOING are dropped, not queued.
- LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1, seed 8'hB8. It free-runs every cycle, including in IDLE. It never reaches zero.
- Timer: one 28-bit counter shared by all timed states. Cleared on every state change and saturates.

## Timing

Reset values:
- `state`=IDLE, `mole_location`=0, `lives`=LIVES_INIT, `score`=0, `whack_pulse`=`miss_pulse`=0, timer=0, lfsr=8'hB8.

Latency and timing rules:
- All outputs are registered. An input sampled at edge N shows its effect on the outputs after edge N+1; there is no combinational path from inputs to outputs.
- Whack latency: `stomp_valid` at cycle N in MOLE_COUNTDOWN gives `state`=6 and `whack_pulse`=1 at N+1, `score` updated at N+2, and `state`=10 at N+2.
- Miss: `state`=5 appears exactly MOLE_TIMEOUT cycles after MOLE_COUNTDOWN is entered.
- `popup_done` is level-sampled, but only in the ascending and descending states. A stale high level in any other state is ignored.
- `reset` asserted in any cycle, including mid-countdown, returns every output to its reset value on the next edge, overriding all other inputs.

## Configuration

- `MOLE_EARLY_WHACK_EN` defined: a matching stomp during MOLE_ASCENDING → MOLE_WHACKED immediately, with the same cycle behaviour as in MOLE_COUNTDOWN.
- `MOLE_EARLY_WHACK_EN` undefined: stomps during MOLE_ASCENDING are ignored; only MOLE_COUNTDOWN stomps count.

## Test plan

All scenarios use START_DELAY=4, MOLE_TIMEOUT=10, SOUND_CYCLES=3, LIVES_INIT=3.

- Reset, then `start` → `state` 0→1, 4 cycles later `state`=2, `lives`=3, `score`=0.
- `note_tick` → `state`=3 for 1 cycle, then 13. Hold `popup_done`=1 → 4. Stomp the matching pad → 6 with `whack_pulse`, then 10 for 3 cycles, then 15. `popup_done` → 2, `score`=1.
- No stomp in MOLE_COUNTDOWN → `state`=5 at cycle 10, `miss_pulse`=1, `lives`=2, then 9 → 14 → 2.
- Matching stomp in the same cycle the timer expires → whack path taken, `lives` unchanged. Non-matching stomp → ignored, miss occurs.
- Three misses → `state`=8 with `lives`=0. `note_tick` ignored. `start` → 0.
- `reset` during MOLE_WHACKED_SOUND → `state`=0, `score`=0 next cycle. Early stomp in MOLE_ASCENDING → `state`=6 with the macro defined, stays 13 without it.
